lvds_tx_frame_ctrl: RTL and testbench
=====================================

# lvds_tx_frame_ctrl

Frame scheduler for the 2-bit LVDS transmit lane. It accepts a frame request and a payload byte stream from the SPI/register side, already synchronised into the `tx_slowclk` domain. It sequences preamble, sync, length, payload and optional CRC onto `lvds_tx_inst1_DATA`, one 2-bit symbol per `tx_slowclk` cycle, and drives idle symbols between frames.

## Interface
Parameters:
- `PREAMBLE_LEN`, default 16: number of training symbols per frame (range 1–255).
- `GAP_LEN`, default 4: number of idle symbols after each frame (range 1–255).
- `SYNC_BYTE`, default 8'hA5: sync byte sent after the preamble.

Ports:
- `tx_slowclk` in 1: the single clock; every register is clocked on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `tx_enable` in 1: level signal that allows new frames to start.
- `start` in 1: frame request; sampled only in IDLE.
- `frame_len` in 8: payload byte count, sampled with `start`; 0 is legal.
- `byte_data` in 8: payload byte.
- `byte_valid` in 1: payload byte available.
- `byte_ready` out 1: block is taking `byte_data` this cycle.
- `busy` out 1: a frame is in progress.
- `done` out 1: one-cycle pulse at the end of a frame.
- `underrun` out 1: one-cycle pulse when a frame is aborted.
- `lvds_tx_inst1_DATA` out 2: registered symbol to the serializer.

## Operation
- States: IDLE, TRAIN, SYNC, LEN, PAYLOAD, CRC, GAP.
- Symbols are sent MSB pair first: `[7:6]`, `[5:4]`, `[3:2]`, `[1:0]`. Every byte occupies 4 cycles.
- Idle symbol is 2'b00. Training symbol is 2'b10.
- IDLE:
  - Outputs the idle symbol.
  - `start && tx_enable` latches `frame_len` and moves to TRAIN.
  - `start` is ignored otherwise, and ignored in every other state.
- TRAIN: `PREAMBLE_LEN` training symbols, then SYNC.
- SYNC: sends `SYNC_BYTE`, then LEN.
- LEN: sends the latched length byte. Next state is PAYLOAD if length > 0, otherwise CRC (or GAP when CRC is compiled out).
- PAYLOAD handshake:
  - `byte_ready` is high only in the 4th symbol cycle of LEN or of a non-final payload byte.
  - The byte moves into the shift register on that edge when `byte_valid` is high.
  - If `byte_valid` is low at that point:
    - `underrun` pulses.
    - The frame aborts to GAP. The remaining bytes and the CRC are not sent.
    - `done` does not pulse for that frame.
- A down-counter tracks remaining bytes. After the last payload byte the state moves to CRC (or GAP).
- GAP: `GAP_LEN` idle symbols. `done` pulses in the final GAP cycle of a non-aborted frame. Next state is IDLE.
- `busy` is high in every state except IDLE.
- If `tx_enable` falls mid-frame, the current frame still completes.
- Reset values:
  - `lvds_tx_inst1_DATA` = 2'b00.
  - `byte_ready`, `busy`, `done`, `underrun` = 0.
  - State = IDLE; counters and CRC = 0.
- Reset asserted mid-frame aborts the frame with no `done` and no `underrun` pulse.

## Timing
- `start` is accepted at edge N. The first training symbol appears on `lvds_tx_inst1_DATA` after edge N+1. The output register adds one cycle.
- Busy duration for a frame of L payload bytes: `PREAMBLE_LEN` + 4·(2 + L + C) + `GAP_LEN` cycles, where C = 1 with CRC and 0 without.
- There is no throughput gap between bytes. The byte handshake occurs at most once every 4 cycles.
- The earliest next `start` is accepted in the cycle after `busy` falls.
- Byte counter and symbol counter are 8 bits. `PREAMBLE_LEN` and `GAP_LEN` counters are 8 bits and load value−1.

## Configuration
- `LVDS_TX_CRC_EN` defined:
  - A CRC state follows the payload.
  - CRC-8, polynomial 0x07, initial value 0x00, no reflection, no final XOR.
  - Computed over the LEN byte and every payload byte, updated one byte at a time when each byte is loaded.
- `LVDS_TX_CRC_EN` not defined:
  - No CRC state and no CRC logic.
  - LEN or the last payload byte goes directly to GAP. C = 0 in the duration formula.

## Structure
- Package `lvds_tx_pkg` holds:
  - the state enum;
  - `IDLE_SYM` = 2'b00 and `TRAIN_SYM` = 2'b10;
  - `CRC8_POLY` = 8'h07;
  - the default `SYNC_BYTE`.
- One sub-module, `lvds_crc8`: a byte-wide CRC-8 update register with `clear` and `load` inputs. It is instantiated only under `LVDS_TX_CRC_EN`.

## Test plan
- Reset held during an active frame, then released: all outputs read 0 and `lvds_tx_inst1_DATA` = 2'b00 in the cycle after the reset edge. A new `start` then produces a clean frame.
- Defaults, CRC on, `frame_len`=3, bytes 0x01 0x02 0x03 always valid:
  - Output is 16× 2'b10, then symbols 2,2,1,1 (0xA5), then 0,0,0,3 (LEN).
  - Payload, then the CRC of {03 01 02 03}, then 4× 2'b00.
  - `busy` lasts 44 cycles and `done` pulses once.
- `frame_len`=0 with CRC compiled out: output is preamble, SYNC, LEN=0x00, then gap. `byte_ready` never asserts and `busy` lasts 28 cycles.
- `frame_len`=4, `byte_valid` dropped before the 3rd byte:
  - 2 bytes are sent, then `underrun` pulses.
  - The output goes to the idle symbol for `GAP_LEN` cycles.
  - No `done` pulse.
- `start` pulsed while busy, and `start` with `tx_enable`=0 in IDLE: both are ignored, with no extra frame and no change in output.
- `tx_enable` deasserted mid-payload: the frame completes with the correct CRC and `done` pulses. A following `start` is ignored until `tx_enable` returns high.

Source files
------------

// File: rtl/lvds_tx_pkg.sv
// Shared types and constants for the LVDS transmit frame scheduler.
// Optional CRC support is selected with LVDS_TX_CRC_EN.
package lvds_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRAIN   = 3'd1,
    ST_SYNC    = 3'd2,
    ST_LEN     = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_CRC     = 3'd5,
    ST_GAP     = 3'd6
  } state_e;

  localparam logic [1:0] IDLE_SYM          = 2'b00;
  localparam logic [1:0] TRAIN_SYM         = 2'b10;
  localparam logic [7:0] CRC8_POLY         = 8'h07;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // One whole byte through CRC-8 (MSB first, no reflection, no final XOR).
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/lvds_crc8.sv
// Byte-wide CRC-8 accumulator; used only when LVDS_TX_CRC_EN is defined.
// clear has priority over load.
module lvds_crc8
  import lvds_tx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      crc <= 8'h00;
    end else if (load) begin
      crc <= crc8_update(crc, data);
    end
  end

endmodule

// File: rtl/lvds_tx_frame_ctrl.sv
// Frame scheduler for the 2-bit LVDS lane: preamble, sync, length, payload,
// optional CRC (LVDS_TX_CRC_EN), then idle gap; one symbol per tx_slowclk cycle.
module lvds_tx_frame_ctrl
  import lvds_tx_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 16,
  parameter int unsigned GAP_LEN      = 4,
  parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic       tx_slowclk,
  input  logic       reset,
  input  logic       tx_enable,
  input  logic       start,
  input  logic [7:0] frame_len,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       busy,
  output logic       done,
  output logic       underrun,
  output logic [1:0] lvds_tx_inst1_DATA
);

  localparam logic [7:0] PRE_LOAD = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_LEN - 1);

  state_e     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [7:0] bytes_left_reg, bytes_left_next;
  logic [7:0] len_reg, len_next;
  logic [7:0] shift_reg, shift_next;
  logic       aborted_reg, aborted_next;
  logic [1:0] data_reg;
  logic [1:0] sym;
  logic       more_bytes;
  logic       ready_raw, underrun_raw, done_raw;

`ifdef LVDS_TX_CRC_EN
  logic [7:0] crc_value;
  logic       crc_clear, crc_load;
  logic [7:0] crc_data;

  assign crc_clear = (state_reg == ST_IDLE);
  assign crc_load  = ((state_reg == ST_SYNC) && (cnt_reg == 8'd0)) || (ready_raw && byte_valid);
  assign crc_data  = (state_reg == ST_SYNC) ? len_reg : byte_data;

  lvds_crc8 u_crc8 (
    .clk   (tx_slowclk),
    .reset (reset),
    .clear (crc_clear),
    .load  (crc_load),
    .data  (crc_data),
    .crc   (crc_value)
  );
`endif

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    bytes_left_next = bytes_left_reg;
    len_next        = len_reg;
    shift_next      = shift_reg;
    aborted_next    = aborted_reg;
    ready_raw       = 1'b0;
    underrun_raw    = 1'b0;
    done_raw        = 1'b0;
    more_bytes      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start && tx_enable) begin
          state_next   = ST_TRAIN;
          cnt_next     = PRE_LOAD;
          len_next     = frame_len;
          aborted_next = 1'b0;
        end
      end
      ST_TRAIN: begin
        if (cnt_reg == 8'd0) begin
          state_next = ST_SYNC;
          cnt_next   = 8'd3;
          shift_next = SYNC_BYTE;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      ST_SYNC: begin
        if (cnt_reg == 8'd0) begin
          state_next = ST_LEN;
          cnt_next   = 8'd3;
          shift_next = len_reg;
        end else begin
          cnt_next   = cnt_reg - 8'd1;
          shift_next = {shift_reg[5:0], 2'b00};
        end
      end
      ST_LEN, ST_PAYLOAD: begin
        if (cnt_reg != 8'd0) begin
          cnt_next   = cnt_reg - 8'd1;
          shift_next = {shift_reg[5:0], 2'b00};
        end else begin
          // Last symbol of a byte: fetch the next one or close out the data phase.
          more_bytes = (state_reg == ST_LEN) ? (len_reg != 8'd0) : (bytes_left_reg != 8'd0);
          if (more_bytes) begin
            ready_raw = 1'b1;
            if (byte_valid) begin
              state_next      = ST_PAYLOAD;
              cnt_next        = 8'd3;
              shift_next      = byte_data;
              bytes_left_next = (state_reg == ST_LEN) ? (len_reg - 8'd1) : (bytes_left_reg - 8'd1);
            end else begin
              underrun_raw = 1'b1;
              aborted_next = 1'b1;
              state_next   = ST_GAP;
              cnt_next     = GAP_LOAD;
            end
          end else begin
`ifdef LVDS_TX_CRC_EN
            state_next = ST_CRC;
            cnt_next   = 8'd3;
            shift_next = crc_value;
`else
            state_next = ST_GAP;
            cnt_next   = GAP_LOAD;
`endif
          end
        end
      end
      ST_CRC: begin
        if (cnt_reg == 8'd0) begin
          state_next = ST_GAP;
          cnt_next   = GAP_LOAD;
        end else begin
          cnt_next   = cnt_reg - 8'd1;
          shift_next = {shift_reg[5:0], 2'b00};
        end
      end
      ST_GAP: begin
        if (cnt_reg == 8'd0) begin
          state_next = ST_IDLE;
          done_raw   = ~aborted_reg;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    case (state_reg)
      ST_TRAIN:                           sym = TRAIN_SYM;
      ST_SYNC, ST_LEN, ST_PAYLOAD, ST_CRC: sym = shift_reg[7:6];
      default:                            sym = IDLE_SYM;
    endcase
  end

  always_ff @(posedge tx_slowclk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= 8'd0;
      bytes_left_reg <= 8'd0;
      len_reg        <= 8'd0;
      shift_reg      <= 8'd0;
      aborted_reg    <= 1'b0;
      data_reg       <= IDLE_SYM;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      bytes_left_reg <= bytes_left_next;
      len_reg        <= len_next;
      shift_reg      <= shift_next;
      aborted_reg    <= aborted_next;
      data_reg       <= sym;
    end
  end

  // Pulses are masked while reset is high so an interrupted frame reports nothing.
  assign byte_ready         = ready_raw & ~reset;
  assign underrun           = underrun_raw & ~reset;
  assign done               = done_raw & ~reset;
  assign busy               = (state_reg != ST_IDLE);
  assign lvds_tx_inst1_DATA = data_reg;

endmodule

// File: tb/tb_lvds_tx_frame_ctrl.sv
// Self-checking bench for lvds_tx_frame_ctrl; adapts CRC expectations to LVDS_TX_CRC_EN.
module tb_lvds_tx_frame_ctrl;

  localparam int         P    = 16;
  localparam int         G    = 4;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef LVDS_TX_CRC_EN
  localparam int C = 1;
`else
  localparam int C = 0;
`endif

  logic       tx_slowclk = 1'b0;
  logic       reset      = 1'b1;
  logic       tx_enable  = 1'b0;
  logic       start      = 1'b0;
  logic [7:0] frame_len  = 8'd0;
  logic [7:0] byte_data  = 8'd0;
  logic       byte_valid = 1'b0;
  logic       byte_ready, busy, done, underrun;
  logic [1:0] lvds_tx_inst1_DATA;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [1:0] exp_q[$];
  logic [7:0] pay[0:7];

  always #5 tx_slowclk = ~tx_slowclk;

  lvds_tx_frame_ctrl dut (
    .tx_slowclk         (tx_slowclk),
    .reset              (reset),
    .tx_enable          (tx_enable),
    .start              (start),
    .frame_len          (frame_len),
    .byte_data          (byte_data),
    .byte_valid         (byte_valid),
    .byte_ready         (byte_ready),
    .busy               (busy),
    .done               (done),
    .underrun           (underrun),
    .lvds_tx_inst1_DATA (lvds_tx_inst1_DATA)
  );

  // Serial (bit-at-a-time) CRC-8, poly 0x07.
  function automatic logic [7:0] crc_bitwise(input logic [7:0] crc_in, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int k = 3; k >= 0; k--) exp_q.push_back(b[2*k +: 2]);
  endtask

  // Runs one frame; returns in the first cycle where busy has fallen.
  task automatic run_frame(input string name, input int len, input int drop_at,
                           input int en_drop_at, input int start_pulse_at);
    int         n_sent, dur, busy_cnt, done_cnt, done_win, unr_cnt, rdy_cnt, fed, sym_bad;
    bit         aborted, hs;
    logic [7:0] crc;
    logic [1:0] exp_sym;
    aborted  = (drop_at >= 0);
    n_sent   = aborted ? drop_at : len;
    busy_cnt = 0; done_cnt = 0; done_win = -1; unr_cnt = 0; rdy_cnt = 0; fed = 0; sym_bad = 0;
    hs       = 1'b0;

    exp_q.delete();
    for (int i = 0; i < P; i++) exp_q.push_back(2'b10);
    push_byte(SYNC);
    push_byte(8'(len));
    crc = crc_bitwise(8'h00, 8'(len));
    for (int i = 0; i < n_sent; i++) begin
      push_byte(pay[i]);
      crc = crc_bitwise(crc, pay[i]);
    end
    if (!aborted && C == 1) push_byte(crc);
    for (int i = 0; i < G; i++) exp_q.push_back(2'b00);
    dur = exp_q.size();

    tx_enable  = 1'b1;
    frame_len  = 8'(len);
    byte_valid = 1'b0;
    start      = 1'b1;
    @(posedge tx_slowclk); #1;
    start = 1'b0;

    for (int w = 0; w <= dur; w++) begin
      if (w > 0) begin
        @(posedge tx_slowclk); #1;
        if (hs) fed++;
      end
      if (w == en_drop_at) tx_enable = 1'b0;
      start      = (w == start_pulse_at);
      byte_valid = (fed < len) && (fed != drop_at);
      byte_data  = (fed < 8) ? pay[fed] : 8'h00;
      #1;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin done_cnt++; done_win = w; end
      if (underrun === 1'b1) unr_cnt++;
      if (byte_ready === 1'b1) rdy_cnt++;
      hs = (byte_ready === 1'b1) && byte_valid;
      if (w == 0) begin
        tests_run++;
        if (lvds_tx_inst1_DATA !== 2'b00 || busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL %s start_latency: data=%b busy=%b, required data=00 busy=1",
                   name, lvds_tx_inst1_DATA, busy);
        end
      end else begin
        exp_sym = exp_q.pop_front();
        tests_run++;
        if (lvds_tx_inst1_DATA !== exp_sym) begin
          tests_failed++;
          sym_bad++;
          if (sym_bad <= 4)
            $display("FAIL %s symbol[%0d]: got %b, required %b", name, w - 1, lvds_tx_inst1_DATA, exp_sym);
        end
      end
    end
    start = 1'b0;

    tests_run++;
    if (busy_cnt !== dur) begin
      tests_failed++;
      $display("FAIL %s busy_cycles: got %0d, required %0d", name, busy_cnt, dur);
    end
    tests_run++;
    if (done_cnt !== (aborted ? 0 : 1) || (!aborted && done_win !== dur - 1)) begin
      tests_failed++;
      $display("FAIL %s done: count %0d at cycle %0d, required %0d at cycle %0d",
               name, done_cnt, done_win, aborted ? 0 : 1, aborted ? -1 : dur - 1);
    end
    tests_run++;
    if (unr_cnt !== (aborted ? 1 : 0)) begin
      tests_failed++;
      $display("FAIL %s underrun: got %0d pulses, required %0d", name, unr_cnt, aborted ? 1 : 0);
    end
    tests_run++;
    if (rdy_cnt !== (aborted ? drop_at + 1 : len) || fed !== n_sent) begin
      tests_failed++;
      $display("FAIL %s byte_ready: got %0d ready/%0d taken, required %0d/%0d",
               name, rdy_cnt, fed, aborted ? drop_at + 1 : len, n_sent);
    end
    $display("[TB] frame %s len=%0d sent=%0d busy=%0d done=%0d underrun=%0d ready=%0d",
             name, len, fed, busy_cnt, done_cnt, unr_cnt, rdy_cnt);
  endtask

  // Holds start for n cycles and expects the block to stay idle.
  task automatic idle_check(input string name, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      start = 1'b1;
      @(posedge tx_slowclk); #2;
      tests_run++;
      if (busy !== 1'b0 || lvds_tx_inst1_DATA !== 2'b00 || done !== 1'b0) begin
        tests_failed++;
        bad++;
        $display("FAIL %s idle[%0d]: busy=%b data=%b done=%b, required 0 00 0",
                 name, i, busy, lvds_tx_inst1_DATA, done);
      end
    end
    start = 1'b0;
    $display("[TB] idle %s cycles=%0d tx_enable=%b bad=%0d", name, n, tx_enable, bad);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge tx_slowclk);
    #2;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || underrun !== 1'b0 || byte_ready !== 1'b0 ||
        lvds_tx_inst1_DATA !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b done=%b underrun=%b ready=%b data=%b, required all 0",
               busy, done, underrun, byte_ready, lvds_tx_inst1_DATA);
    end
    reset = 1'b0;
    pay[0] = 8'h11; pay[1] = 8'h22;
    tx_enable = 1'b1; frame_len = 8'd2; byte_valid = 1'b1; byte_data = 8'h11; start = 1'b1;
    @(posedge tx_slowclk); #1;
    start = 1'b0;
    repeat (24) @(posedge tx_slowclk);
    #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if (done !== 1'b0 || underrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pulses: done=%b underrun=%b, required 0 0", done, underrun);
    end
    @(posedge tx_slowclk); #2;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || underrun !== 1'b0 || byte_ready !== 1'b0 ||
        lvds_tx_inst1_DATA !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_midframe: busy=%b done=%b underrun=%b ready=%b data=%b, required all 0",
               busy, done, underrun, byte_ready, lvds_tx_inst1_DATA);
    end
    $display("[TB] reset mid-frame busy=%b data=%b", busy, lvds_tx_inst1_DATA);
    @(posedge tx_slowclk); #1;
    reset = 1'b0;
    byte_valid = 1'b0;
    run_frame("after_reset", 2, -1, -1, -1);
  endtask

  task automatic test_crc_frame();
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
    run_frame("len3", 3, -1, -1, -1);
  endtask

  task automatic test_zero_len();
    run_frame("len0", 0, -1, -1, -1);
  endtask

  task automatic test_underrun();
    pay[0] = 8'hC3; pay[1] = 8'h5A; pay[2] = 8'hFF; pay[3] = 8'h81;
    run_frame("underrun", 4, 2, -1, -1);
  endtask

  task automatic test_ignored_start();
    tx_enable = 1'b0;
    idle_check("no_enable", 5);
    pay[0] = 8'h9E; pay[1] = 8'h37;
    run_frame("start_while_busy", 2, -1, -1, 10);
  endtask

  task automatic test_enable_drop();
    pay[0] = 8'hE7; pay[1] = 8'h4C; pay[2] = 8'hB2;
    run_frame("enable_drop", 3, -1, 30, -1);
    idle_check("enable_low_after", 6);
    pay[0] = 8'h6D;
    run_frame("enable_back", 1, -1, -1, -1);
  endtask

  task automatic test_back_to_back();
    pay[0] = 8'hF0; pay[1] = 8'h0F;
    run_frame("b2b_first", 2, -1, -1, -1);
    pay[0] = 8'hAA;
    run_frame("b2b_second", 1, -1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_crc_frame();
    test_zero_len();
    test_underrun();
    test_ignored_start();
    test_enable_drop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
